// File: rtl/md_scheduler.sv
// md_scheduler
//   Sequencing controller for the E-stage multiply/divide unit and the HI/LO
//   register pair. One HI/LO-writing instruction may issue per cycle. Long
//   operations (MULT/MULTU/DIV/DIVU) occupy the unit for a fixed latency and then
//   commit to HI/LO. MTHI/MTLO write HI/LO directly at the issue edge.
//
//   Build option: define MD_DIV_EN to build the divider. Without it, DIV/DIVU
//   (md_op 2/3) are reserved no-ops and DIV_CYCLES is unused.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports
//   clk         pipeline clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       E stage holds a valid HI/LO-writing instruction
//   md_op[2:0]  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   rs_val      forwarded rs operand
//   rt_val      forwarded rt operand
//   d_md_instr  D-stage instruction reads or writes HI/LO
//   busy        long operation in flight
//   stall_d     freeze PC and F/D register, bubble into E
//   done        one-cycle pulse when a long operation commits
//   hi, lo      HI and LO registers
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_instr,
  output logic        busy,
  output logic        stall_d,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        op_long;
  logic        accept;
  logic [63:0] res;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ax, bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

`ifdef MD_DIV_EN
  // Results are packed {remainder, quotient} to match {hi, lo}.
  function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
    if (d == 32'd0) return {n, 32'hFFFF_FFFF};
    return {n % d, n / d};
  endfunction

  // Signed divide on magnitudes; the 0x8000_0000 / -1 overflow falls out
  // naturally as quotient 0x8000_0000, remainder 0.
  function automatic logic [63:0] div_s(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] nm, dm, q, r;
    if (d == 32'd0) return {n, 32'hFFFF_FFFF};
    nm = n[31] ? (32'd0 - n) : n;
    dm = d[31] ? (32'd0 - d) : d;
    q  = nm / dm;
    r  = nm % dm;
    if (n[31] ^ d[31]) q = 32'd0 - q;
    if (n[31])         r = 32'd0 - r;
    return {r, q};
  endfunction
`endif

`ifdef MD_DIV_EN
  assign op_long = (md_op <= 3'd3);
`else
  assign op_long = (md_op <= 3'd1);
`endif

  assign accept  = (state_q == IDLE) & start & op_long;
  assign busy    = (state_q == BUSY);
  assign stall_d = d_md_instr & (busy | (start & op_long));
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Commit result from the latched operands.
  always_comb begin
    res = {hi_q, lo_q};
    case (op_q)
      2'd0:    res = mul_s(a_q, b_q);
      2'd1:    res = mul_u(a_q, b_q);
`ifdef MD_DIV_EN
      2'd2:    res = div_s(a_q, b_q);
      default: res = div_u(a_q, b_q);
`else
      default: res = {hi_q, lo_q};
`endif
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_long) begin
            state_d = BUSY;
            // md_op[1] can only be set here when the divider is built.
            cnt_d   = md_op[1] ? DIV_CYCLES[3:0] : MULT_CYCLES[3:0];
          end else if (md_op == 3'd4) begin
            hi_d = rs_val;
          end else if (md_op == 3'd5) begin
            lo_d = rs_val;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          hi_d    = res[63:32];
          lo_d    = res[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand latch: data only, qualified by acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= rs_val;
      b_q  <= rt_val;
      op_q <= md_op[1:0];
    end
  end

endmodule
